// File: rtl/mem_region_router_pkg.sv
// ----------------------------------------------------------------------------
// mem_region_router_pkg
//   Shared types and constants for the memory region router.
//   - rsp_code_e    : response code carried in each ordering tag
//   - DEF_*         : default address map (region0 = instr RAM at 0x0000_0000,
//                     region1 = data RAM at 0x1000_0000, 64 KiB each,
//                     region0 read-only)
//   - idx_width()   : width of a region index for a given region count
//   The ordering tag itself is {code, idx}. Its idx field is sized from the
//   router's NREG parameter, so the router declares the tag struct locally.
// ----------------------------------------------------------------------------
package mem_region_router_pkg;

    localparam int unsigned DEF_AW   = 32;
    localparam int unsigned DEF_DW   = 32;
    localparam int unsigned DEF_NREG = 2;

    localparam logic [DEF_NREG*DEF_AW-1:0] DEF_REGION_BASE = {32'h1000_0000, 32'h0000_0000};
    localparam logic [DEF_NREG*DEF_AW-1:0] DEF_REGION_MASK = {2{32'hFFFF_0000}};
    localparam logic [DEF_NREG-1:0]        DEF_REGION_RO   = 2'b01;

    typedef enum logic {
        RSP_OKAY  = 1'b0,
        RSP_FAULT = 1'b1
    } rsp_code_e;

    // A single region still needs a 1-bit index so that vectors stay legal.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_region_router_if.sv
// ----------------------------------------------------------------------------
// mem_region_router_if
//   Upstream request/response bus between the core (LSU/fetch) and the
//   router. Signal names keep the router's port naming (_in/_out as seen by
//   the router).
//   Handshake: a beat transfers on a rising clk edge where valid and ready
//   are both high; a source holds valid and its payload stable until that
//   edge, and ready may depend combinationally on valid/payload.
//   modport master : core side (drives requests, accepts responses)
//   modport slave  : router side
// ----------------------------------------------------------------------------
interface mem_region_router_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic            req_valid_in;
    logic            req_ready_out;
    logic [AW-1:0]   req_addr_in;
    logic            req_write_in;
    logic [DW-1:0]   req_wdata_in;
    logic [DW/8-1:0] req_wstrb_in;
    logic            rsp_valid_out;
    logic            rsp_ready_in;
    logic [DW-1:0]   rsp_rdata_out;
    logic            rsp_err_out;

    modport master (
        output req_valid_in, req_addr_in, req_write_in, req_wdata_in, req_wstrb_in,
        output rsp_ready_in,
        input  req_ready_out, rsp_valid_out, rsp_rdata_out, rsp_err_out
    );

    modport slave (
        input  req_valid_in, req_addr_in, req_write_in, req_wdata_in, req_wstrb_in,
        input  rsp_ready_in,
        output req_ready_out, rsp_valid_out, rsp_rdata_out, rsp_err_out
    );
endinterface

// File: rtl/mem_region_router_tag_fifo.sv
// ----------------------------------------------------------------------------
// mem_region_router_tag_fifo
//   Synchronous FIFO holding the ordering tags of accepted requests.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset (empties FIFO)
//     push, push_data write a tag (ignored when full)
//     pop             drop the head tag (ignored when empty)
//     head_data       current head tag (meaningless while empty)
//     full, empty     registered status, derived from the pointers
//   Pointers carry one extra bit so full and empty are distinguishable
//   when the index parts are equal.
// ----------------------------------------------------------------------------
module mem_region_router_tag_fifo #(
    parameter int unsigned W     = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         full,
    output logic         empty
);
    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = PW + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [W-1:0]     mem_q [DEPTH];

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                       (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign head_data = mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_ptr_q[PW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/mem_region_router.sv
// ----------------------------------------------------------------------------
// mem_region_router
//   Routes one upstream request stream onto NREG address-mapped regions and
//   returns one response per accepted request, in acceptance order.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     up              upstream bus (mem_region_router_if.slave)
//     reg_valid_out   per-region request valid (one-hot or zero)
//     reg_ready_in    per-region request ready
//     reg_addr_out, reg_write_out, reg_wdata_out, reg_wstrb_out
//                     shared request payload (pass-through of upstream)
//     reg_rvalid_in   per-region response pulse (reads and writes)
//     reg_rdata_in    per-region read data, region i at [i*DW +: DW]
//   Each region has at most one request in flight (busy). Its response is
//   parked in a per-region holding register until the ordering FIFO head
//   points at it, so upstream responses never depend combinationally on
//   region inputs. Faults (unmapped, or write to a read-only region) never
//   reach a region; they answer as soon as they reach the FIFO head.
// ----------------------------------------------------------------------------
module mem_region_router
    import mem_region_router_pkg::*;
#(
    parameter int unsigned          AW          = DEF_AW,
    parameter int unsigned          DW          = DEF_DW,
    parameter int unsigned          NREG        = DEF_NREG,
    parameter int unsigned          OUT_DEPTH   = 4,
    parameter logic [NREG*AW-1:0]   REGION_BASE = DEF_REGION_BASE,
    parameter logic [NREG*AW-1:0]   REGION_MASK = DEF_REGION_MASK,
    parameter logic [NREG-1:0]      REGION_RO   = DEF_REGION_RO
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_region_router_if.slave   up,
    output logic [NREG-1:0]      reg_valid_out,
    input  logic [NREG-1:0]      reg_ready_in,
    output logic [AW-1:0]        reg_addr_out,
    output logic                 reg_write_out,
    output logic [DW-1:0]        reg_wdata_out,
    output logic [DW/8-1:0]      reg_wstrb_out,
    input  logic [NREG-1:0]      reg_rvalid_in,
    input  logic [NREG*DW-1:0]   reg_rdata_in
);
    localparam int unsigned IDX_W = idx_width(NREG);

    typedef struct packed {
        rsp_code_e        code;
        logic [IDX_W-1:0] idx;
    } tag_t;

    localparam int unsigned TAG_W = $bits(tag_t);

    // ---------------- decode ----------------
    logic [NREG-1:0]  hit;
    logic [IDX_W-1:0] tgt;
    logic             fault;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NREG; i++) begin
            hit[i] = ((up.req_addr_in & REGION_MASK[i*AW +: AW]) == REGION_BASE[i*AW +: AW]);
        end
    end

    // Scan downwards so the lowest-index hit is the one left standing.
    always_comb begin
        tgt = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (hit[i]) begin
                tgt = IDX_W'(i);
            end
        end
    end

    assign fault = !(|hit) || (up.req_write_in && REGION_RO[tgt]);

    // ---------------- ordering FIFO ----------------
    tag_t push_tag;
    tag_t head;
    logic fifo_full;
    logic fifo_empty;
    logic accept;
    logic pop;
    logic head_fault;

    assign push_tag.code = fault ? RSP_FAULT : RSP_OKAY;
    assign push_tag.idx  = tgt;

    mem_region_router_tag_fifo #(
        .W     (TAG_W),
        .DEPTH (OUT_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (push_tag),
        .pop       (pop),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_fault = (head.code == RSP_FAULT);

    // ---------------- per-region state ----------------
    logic [NREG-1:0] busy_q, busy_d;
    logic [NREG-1:0] hold_valid_q, hold_valid_d;
    logic [NREG-1:0] wr_q, wr_d;           // in-flight request is a write
    logic [DW-1:0]   hold_q [NREG];
    logic [DW-1:0]   hold_d [NREG];

    // A region whose response is being popped this cycle counts as free,
    // so a back-to-back request to it is accepted in the same cycle.
    logic [NREG-1:0] busy_eff;
    logic            tgt_busy;

    always_comb begin
        busy_eff = busy_q;
        if (pop && !head_fault) begin
            busy_eff[head.idx] = 1'b0;
        end
    end

    assign tgt_busy = busy_eff[tgt];

    // ---------------- issue path ----------------
    // Full is the registered flag: a pop does not make room for a push in
    // the same cycle.
    assign up.req_ready_out = !rst && !fifo_full &&
                              (fault || (!tgt_busy && reg_ready_in[tgt]));
    assign accept           = up.req_valid_in && up.req_ready_out;

    always_comb begin
        reg_valid_out = '0;
        if (!rst && up.req_valid_in && !fault && !tgt_busy && !fifo_full) begin
            reg_valid_out[tgt] = 1'b1;
        end
    end

    assign reg_addr_out  = up.req_addr_in;
    assign reg_write_out = up.req_write_in;
    assign reg_wdata_out = up.req_wdata_in;
    assign reg_wstrb_out = up.req_wstrb_in;

    // ---------------- response path ----------------
    logic rsp_valid;

    assign rsp_valid        = !fifo_empty && (head_fault || hold_valid_q[head.idx]);
    assign pop              = rsp_valid && up.rsp_ready_in;
    assign up.rsp_valid_out = rsp_valid;
    assign up.rsp_err_out   = rsp_valid && head_fault;
    assign up.rsp_rdata_out = (rsp_valid && !head_fault) ? hold_q[head.idx] : '0;

    always_comb begin
        busy_d       = busy_q;
        hold_valid_d = hold_valid_q;
        wr_d         = wr_q;
        hold_d       = hold_q;

        // Responses from a region with nothing in flight are dropped.
        for (int i = 0; i < NREG; i++) begin
            if (reg_rvalid_in[i] && busy_q[i]) begin
                hold_valid_d[i] = 1'b1;
                hold_d[i]       = wr_q[i] ? '0 : reg_rdata_in[i*DW +: DW];
            end
        end

        if (pop && !head_fault) begin
            busy_d[head.idx]       = 1'b0;
            hold_valid_d[head.idx] = 1'b0;
        end

        // Applied after the pop so a same-cycle reissue keeps the region busy.
        if (accept && !fault) begin
            busy_d[tgt] = 1'b1;
            wr_d[tgt]   = up.req_write_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q       <= '0;
            hold_valid_q <= '0;
            wr_q         <= '0;
            for (int i = 0; i < NREG; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            busy_q       <= busy_d;
            hold_valid_q <= hold_valid_d;
            wr_q         <= wr_d;
            hold_q       <= hold_d;
        end
    end

endmodule
